// File: rtl/hazard_flush_controller.sv
// Load-use / control hazard sequencer for the 16-bit RISC pipeline.
// Optional perf counters (stallCount, flushCount) enabled by HAZARD_PERF_CNT_EN.
module hazard_flush_controller #(
  parameter int unsigned REG_ADDR_W        = 4,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned BRANCH_PENALTY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_useRt,
  input  logic                  id_jump,
  input  logic                  ex_memRead,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_braTaken,
  output logic                  pcWrite,
  output logic                  ifidWrite,
  output logic                  ifidFlush,
  output logic                  ctrlFlushSel,
  output logic                  busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]           stallCount,
  output logic [15:0]           flushCount
`endif
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_LD_STALL = 2'd1;
  localparam logic [1:0] S_BR_FLUSH = 2'd2;

  localparam logic [2:0] LD_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] BR_INIT = 3'(BRANCH_PENALTY - 1);

  logic [1:0] r_state;
  logic [2:0] r_cnt;
  logic [1:0] w_nxt_state;
  logic [2:0] w_nxt_cnt;
  logic       w_loadUse;

  assign w_loadUse = ex_memRead && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (id_useRt && (ex_rd == id_rt)));

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_cnt    = r_cnt;
    pcWrite      = 1'b1;
    ifidWrite    = 1'b1;
    ifidFlush    = 1'b0;
    ctrlFlushSel = 1'b0;
    busy         = (r_state != S_RUN);

    case (r_state)
      S_BR_FLUSH: begin
        ifidFlush    = 1'b1;
        ctrlFlushSel = 1'b1;
        w_nxt_cnt    = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) begin
          w_nxt_state = S_RUN;
          w_nxt_cnt   = '0;
        end
      end
      default: begin
        // RUN and LD_STALL share the branch override; a taken branch wins over any stall
        if (ex_braTaken) begin
          ifidFlush    = 1'b1;
          ctrlFlushSel = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            w_nxt_state = S_BR_FLUSH;
            w_nxt_cnt   = BR_INIT;
          end else begin
            w_nxt_state = S_RUN;
            w_nxt_cnt   = '0;
          end
        end else if (r_state == S_LD_STALL) begin
          pcWrite      = 1'b0;
          ifidWrite    = 1'b0;
          ctrlFlushSel = 1'b1;
          w_nxt_cnt    = r_cnt - 3'd1;
          if (r_cnt <= 3'd1) begin
            w_nxt_state = S_RUN;
            w_nxt_cnt   = '0;
          end
        end else if (w_loadUse) begin
          pcWrite      = 1'b0;
          ifidWrite    = 1'b0;
          ctrlFlushSel = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_nxt_state = S_LD_STALL;
            w_nxt_cnt   = LD_INIT;
          end
        end else if (id_jump) begin
          ifidFlush = 1'b1;
        end
      end
    endcase

    if (rst) begin
      pcWrite      = 1'b0;
      ifidWrite    = 1'b0;
      ifidFlush    = 1'b1;
      ctrlFlushSel = 1'b1;
      busy         = 1'b0;
      w_nxt_state  = S_RUN;
      w_nxt_cnt    = '0;
    end
  end

  always_ff @(posedge clk) begin
    r_state <= w_nxt_state;
    r_cnt   <= w_nxt_cnt;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stallCount;
  logic [15:0] r_flushCount;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (!pcWrite && (r_stallCount != '1)) r_stallCount <= r_stallCount + 16'd1;
      if (ctrlFlushSel && (r_flushCount != '1)) r_flushCount <= r_flushCount + 16'd1;
    end
  end

  assign stallCount = r_stallCount;
  assign flushCount = r_flushCount;
`endif

endmodule

// File: tb/tb_hazard_flush_controller.sv
// Directed bench: instance A uses defaults (1 load bubble, branch penalty 2),
// instance B uses 3 load bubbles and branch penalty 1.
module tb_hazard_flush_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
  logic a_useRt, a_jump, a_mr, a_br, b_useRt, b_jump, b_mr, b_br;
  logic a_pc, a_ifw, a_iff, a_cfs, a_busy;
  logic b_pc, b_ifw, b_iff, b_cfs, b_busy;
  logic [4:0] a_o, b_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] a_sc, a_fc, b_sc, b_fc;
`endif

  assign a_o = {a_pc, a_ifw, a_iff, a_cfs, a_busy};
  assign b_o = {b_pc, b_ifw, b_iff, b_cfs, b_busy};

  // {pcWrite, ifidWrite, ifidFlush, ctrlFlushSel, busy}
  localparam logic [4:0] O_RST   = 5'b00110;
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_STB   = 5'b00011;
  localparam logic [4:0] O_BR    = 5'b11110;
  localparam logic [4:0] O_BRB   = 5'b11111;
  localparam logic [4:0] O_JMP   = 5'b11100;

  hazard_flush_controller u_a (
    .clk(clk), .rst(rst), .id_rs(a_rs), .id_rt(a_rt), .id_useRt(a_useRt),
    .id_jump(a_jump), .ex_memRead(a_mr), .ex_rd(a_rd), .ex_braTaken(a_br),
    .pcWrite(a_pc), .ifidWrite(a_ifw), .ifidFlush(a_iff),
    .ctrlFlushSel(a_cfs), .busy(a_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCount(a_sc), .flushCount(a_fc)
`endif
  );

  hazard_flush_controller #(.LOAD_STALL_CYCLES(3), .BRANCH_PENALTY(1)) u_b (
    .clk(clk), .rst(rst), .id_rs(b_rs), .id_rt(b_rt), .id_useRt(b_useRt),
    .id_jump(b_jump), .ex_memRead(b_mr), .ex_rd(b_rd), .ex_braTaken(b_br),
    .pcWrite(b_pc), .ifidWrite(b_ifw), .ifidFlush(b_iff),
    .ctrlFlushSel(b_cfs), .busy(b_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCount(b_sc), .flushCount(b_fc)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setA(input logic br, input logic mr, input logic [3:0] rd,
                      input logic [3:0] rs, input logic [3:0] rt,
                      input logic urt, input logic jmp);
    a_br = br; a_mr = mr; a_rd = rd; a_rs = rs; a_rt = rt; a_useRt = urt; a_jump = jmp;
  endtask

  task automatic setB(input logic br, input logic mr, input logic [3:0] rd,
                      input logic [3:0] rs, input logic [3:0] rt,
                      input logic urt, input logic jmp);
    b_br = br; b_mr = mr; b_rd = rd; b_rs = rs; b_rt = rt; b_useRt = urt; b_jump = jmp;
  endtask

  initial begin
    // reset held two cycles with a taken branch present
    rst = 1'b1;
    setA(1, 0, 0, 0, 0, 0, 0);
    setB(1, 0, 0, 0, 0, 0, 0);
    #1 chk("a_rst_c1", a_o, O_RST); chk("b_rst_c1", b_o, O_RST);
    @(negedge clk); #1 chk("a_rst_c2", a_o, O_RST); chk("b_rst_c2", b_o, O_RST);
    @(negedge clk); rst = 1'b0;
    setA(0, 0, 0, 0, 0, 0, 0); setB(0, 0, 0, 0, 0, 0, 0);
    #1 chk("a_rel", a_o, O_RUN); chk("b_rel", b_o, O_RUN);

    // A: single-bubble load-use on rs
    @(negedge clk); setA(0, 1, 3, 3, 0, 0, 0);
    #1 chk("a_lu_rs", a_o, O_STALL);
    @(negedge clk); setA(0, 0, 3, 3, 0, 0, 0);
    #1 chk("a_lu_after", a_o, O_RUN);
    @(negedge clk); setA(0, 1, 0, 0, 0, 0, 0);
    #1 chk("a_lu_r0", a_o, O_RUN);
    @(negedge clk); setA(0, 1, 5, 1, 5, 0, 0);
    #1 chk("a_lu_rt_unused", a_o, O_RUN);

    // A: back-to-back load-use hazards
    @(negedge clk); setA(0, 1, 4, 2, 4, 1, 0);
    #1 chk("a_b2b_1", a_o, O_STALL);
    @(negedge clk); setA(0, 1, 7, 7, 0, 0, 0);
    #1 chk("a_b2b_2", a_o, O_STALL);

    // A: taken branch, loadUse in the flush cycle is ignored
    @(negedge clk); setA(1, 0, 0, 0, 0, 0, 0);
    #1 chk("a_br_c1", a_o, O_BR);
    @(negedge clk); setA(0, 1, 3, 3, 0, 0, 1);
    #1 chk("a_br_c2", a_o, O_BRB);
    @(negedge clk); setA(0, 0, 0, 0, 0, 0, 0);
    #1 chk("a_br_done", a_o, O_RUN);

    // A: branch + loadUse + jump together, branch wins
    @(negedge clk); setA(1, 1, 6, 6, 0, 0, 1);
    #1 chk("a_all_c1", a_o, O_BR);
    @(negedge clk); setA(0, 0, 0, 0, 0, 0, 0);
    #1 chk("a_all_c2", a_o, O_BRB);
    @(negedge clk); #1 chk("a_all_done", a_o, O_RUN);

    // A: jump only
    @(negedge clk); setA(0, 0, 0, 0, 0, 0, 1);
    #1 chk("a_jmp", a_o, O_JMP);
    @(negedge clk); setA(0, 0, 0, 0, 0, 0, 0);
    #1 chk("a_jmp_done", a_o, O_RUN);

    // B: three-bubble load-use via rt
    @(negedge clk); setB(0, 1, 5, 0, 5, 1, 0);
    #1 chk("b_lu_c1", b_o, O_STALL);
    @(negedge clk); setB(0, 0, 0, 0, 0, 0, 0);
    #1 chk("b_lu_c2", b_o, O_STB);
    @(negedge clk); #1 chk("b_lu_c3", b_o, O_STB);
    @(negedge clk); #1 chk("b_lu_done", b_o, O_RUN);
    @(negedge clk); setB(0, 1, 5, 0, 5, 0, 0);
    #1 chk("b_lu_norT", b_o, O_RUN);

    // B: branch penalty 1 stays in RUN
    @(negedge clk); setB(1, 0, 0, 0, 0, 0, 0);
    #1 chk("b_br_c1", b_o, O_BR);
    @(negedge clk); setB(0, 0, 0, 0, 0, 0, 0);
    #1 chk("b_br_done", b_o, O_RUN);

    // B: branch overrides an in-progress stall
    @(negedge clk); setB(0, 1, 9, 9, 0, 0, 0);
    #1 chk("b_ovr_c1", b_o, O_STALL);
    @(negedge clk); setB(1, 0, 0, 0, 0, 0, 0);
    #1 chk("b_ovr_c2", b_o, O_BRB);
    @(negedge clk); setB(0, 0, 0, 0, 0, 0, 0);
    #1 chk("b_ovr_done", b_o, O_RUN);

    // B: reset mid-stall leaves no residual bubble
    @(negedge clk); setB(0, 1, 2, 2, 0, 0, 0);
    #1 chk("b_rs_c1", b_o, O_STALL);
    @(negedge clk); rst = 1'b1; setB(0, 0, 0, 0, 0, 0, 0);
    #1 chk("b_rs_rst", b_o, O_RST); chk("a_rs_rst", a_o, O_RST);
    @(negedge clk); rst = 1'b0;
    #1 chk("b_rs_after", b_o, O_RUN); chk("a_rs_after", a_o, O_RUN);

`ifdef HAZARD_PERF_CNT_EN
    @(negedge clk); rst = 1'b1; setA(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    #1 chk("pc_stall_clr0", a_sc, 16'd0); chk("pc_flush_clr0", a_fc, 16'd0);
    setA(0, 1, 3, 3, 0, 0, 0);
    @(negedge clk); setA(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); setA(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 chk("pc_stall", a_sc, 16'd1); chk("pc_flush", a_fc, 16'd3);
    rst = 1'b1;
    @(negedge clk);
    #1 chk("pc_stall_rst", a_sc, 16'd0); chk("pc_flush_rst", a_fc, 16'd0);
    rst = 1'b0;
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
